ce_gen_multi: RTL and testbench

CE_GEN_MULTI -- requirements
Module: ce_gen_multi

---
 rtl/ce_gen_pkg.sv | 51 +++++
 rtl/ce_gen_chan.sv | 101 ++++++++++
 rtl/ce_gen_multi.sv | 84 ++++++++
 tb/tb_ce_gen_multi.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ce_gen_pkg.sv
// ---------------------------------------------------------------------------
// ce_gen_pkg
// Shared types and reset defaults for the multi-channel clock-enable generator.
//
// Contents:
//    CE_MAX_W      widest supported divide count; config fields are stored at
//                  this width and narrowed to DIV_WIDTH inside each channel
//    CE_RST_DIV    default reset divide count
//    CE_RST_DIV2   default reset divide-by-2 mode
//    ce_cfg_t      one channel configuration (div, div2, and phase when the
//                  CE_GEN_PHASE_EN macro is defined)
//    reset_cfg()   builds the reset configuration
//    sync_load()   counter value loaded when sync_i realigns a channel
//
// Optional feature: define CE_GEN_PHASE_EN to add the per-channel phase.
// ---------------------------------------------------------------------------
package ce_gen_pkg;

   localparam int CE_MAX_W    = 16;
   localparam int CE_RST_DIV  = 31;
   localparam bit CE_RST_DIV2 = 1'b0;

   typedef struct packed {
      logic [CE_MAX_W-1:0] div;
      logic                div2;
`ifdef CE_GEN_PHASE_EN
      logic [CE_MAX_W-1:0] phase;
`endif
   } ce_cfg_t;

   // The reset phase is all ones so that min(phase, div) collapses to div:
   // a channel nobody has configured realigns exactly like the phase-less build.
   function automatic ce_cfg_t reset_cfg(input int div, input logic div2);
      ce_cfg_t c;
      c.div  = CE_MAX_W'(div);
      c.div2 = div2;
`ifdef CE_GEN_PHASE_EN
      c.phase = '1;
`endif
      return c;
   endfunction

   function automatic logic [CE_MAX_W-1:0] sync_load(input ce_cfg_t c);
`ifdef CE_GEN_PHASE_EN
      return (c.phase < c.div) ? c.phase : c.div;
`else
      return c.div;
`endif
   endfunction

endpackage

// File: rtl/ce_gen_chan.sv
// ---------------------------------------------------------------------------
// ce_gen_chan
// One clock-enable channel: a down-counter with an active and a shadow
// configuration. Shadow updates are applied only at a terminal count or on
// sync_i, so a period is never cut short.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    sync_i     realign: apply pending config, clear toggle, reload counter
//    wr_i       configuration write addressed to this channel
//    wr_cfg_i   configuration carried by the write
//    pending_o  a written configuration is waiting to be applied
//    ce_o       registered clock-enable pulse
//
// Optional feature: CE_GEN_PHASE_EN (phase carried inside ce_cfg_t).
// ---------------------------------------------------------------------------
module ce_gen_chan
   import ce_gen_pkg::*;
#(
   parameter int DIV_WIDTH    = 8,
   parameter int DEFAULT_DIV  = CE_RST_DIV,
   parameter bit DEFAULT_DIV2 = CE_RST_DIV2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    sync_i,
   input  logic    wr_i,
   input  ce_cfg_t wr_cfg_i,
   output logic    pending_o,
   output logic    ce_o
);

   localparam ce_cfg_t RST_CFG = reset_cfg(DEFAULT_DIV, DEFAULT_DIV2);

   ce_cfg_t              active_q;
   ce_cfg_t              shadow_q;
   ce_cfg_t              sync_cfg;
   logic [DIV_WIDTH-1:0] cnt_q;
   logic                 toggle_q;
   logic                 pending_q;
   logic                 ce_q;
   logic                 tc;

   assign tc = (cnt_q == '0);

   // Configuration that a sync adopts: a write in the same cycle wins over an
   // older pending shadow, which in turn wins over the active setting.
   always_comb begin
      sync_cfg = active_q;
      if (wr_i) begin
         sync_cfg = wr_cfg_i;
      end else if (pending_q) begin
         sync_cfg = shadow_q;
      end
   end

   // ce_o is computed from the current counter and active mode before any
   // reload, so a terminal count coinciding with sync still produces its pulse.
   // A write landing on the same edge as an unsynced terminal count stays
   // pending for the following period; the older shadow is applied now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= DIV_WIDTH'(DEFAULT_DIV);
         active_q  <= RST_CFG;
         shadow_q  <= RST_CFG;
         toggle_q  <= 1'b0;
         pending_q <= 1'b0;
         ce_q      <= 1'b0;
      end else begin
         ce_q <= tc & (~active_q.div2 | toggle_q);
         if (wr_i) begin
            shadow_q <= wr_cfg_i;
         end
         if (sync_i) begin
            active_q  <= sync_cfg;
            cnt_q     <= DIV_WIDTH'(sync_load(sync_cfg));
            toggle_q  <= 1'b0;
            pending_q <= 1'b0;
         end else begin
            pending_q <= wr_i | (pending_q & ~tc);
            if (tc) begin
               if (pending_q) begin
                  active_q <= shadow_q;
                  cnt_q    <= DIV_WIDTH'(shadow_q.div);
                  toggle_q <= 1'b0;
               end else begin
                  cnt_q    <= DIV_WIDTH'(active_q.div);
                  toggle_q <= ~toggle_q;
               end
            end else begin
               cnt_q <= cnt_q - DIV_WIDTH'(1);
            end
         end
      end
   end

   assign pending_o = pending_q;
   assign ce_o      = ce_q;

endmodule

// File: rtl/ce_gen_multi.sv
// ---------------------------------------------------------------------------
// ce_gen_multi
// NCH independent programmable clock-enable generators sharing one clock,
// one configuration write port and one realignment pulse.
//
// Parameters:
//    NCH          number of channels (1..16)
//    DIV_WIDTH    divide-count width (1..16)
//    DEFAULT_DIV  reset divide count of every channel
//    DEFAULT_DIV2 reset divide-by-2 mode of every channel
//
// Ports:
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    sync_i       one-cycle pulse realigning all channels
//    cfg_wr_i     configuration write strobe
//    cfg_ch_i     target channel; values >= NCH are ignored
//    cfg_div_i    new divide count (period div+1)
//    cfg_div2_i   new divide-by-2 mode (period 2*(div+1))
//    cfg_phase_i  new phase offset (only with CE_GEN_PHASE_EN)
//    pending_o    per channel: configuration waiting to be applied
//    ce_o         per channel: registered clock-enable pulse
//
// Optional feature: define CE_GEN_PHASE_EN to add per-channel phase offsets
// used when sync_i realigns the counters.
// ---------------------------------------------------------------------------
module ce_gen_multi
   import ce_gen_pkg::*;
#(
   parameter int  NCH          = 4,
   parameter int  DIV_WIDTH    = 8,
   parameter int  DEFAULT_DIV  = CE_RST_DIV,
   parameter bit  DEFAULT_DIV2 = CE_RST_DIV2,
   localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sync_i,
   input  logic                 cfg_wr_i,
   input  logic [CH_W-1:0]      cfg_ch_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic                 cfg_div2_i,
`ifdef CE_GEN_PHASE_EN
   input  logic [DIV_WIDTH-1:0] cfg_phase_i,
`endif
   output logic [NCH-1:0]       pending_o,
   output logic [NCH-1:0]       ce_o
);

   ce_cfg_t wr_cfg;

   // Widen the write data once; every channel sees the same struct and only
   // the addressed one acts on it.
   always_comb begin
      wr_cfg      = '0;
      wr_cfg.div  = CE_MAX_W'(cfg_div_i);
      wr_cfg.div2 = cfg_div2_i;
`ifdef CE_GEN_PHASE_EN
      wr_cfg.phase = CE_MAX_W'(cfg_phase_i);
`endif
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      logic wr_hit;

      // Out-of-range channel numbers never match any g, so they are dropped.
      assign wr_hit = cfg_wr_i && (cfg_ch_i == CH_W'(g));

      ce_gen_chan #(
         .DIV_WIDTH   (DIV_WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV),
         .DEFAULT_DIV2(DEFAULT_DIV2)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .sync_i    (sync_i),
         .wr_i      (wr_hit),
         .wr_cfg_i  (wr_cfg),
         .pending_o (pending_o[g]),
         .ce_o      (ce_o[g])
      );
   end

endmodule

// File: tb/tb_ce_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_ce_gen_multi
// Directed bench for ce_gen_multi with default parameters (NCH=4, DIV_WIDTH=8,
// DEFAULT_DIV=31). Edges are numbered from reset release: edge 1 is the first
// rising edge after rst_n goes high. Inputs are driven 1 time unit after an
// edge and outputs are sampled at the same point.
// With CE_GEN_PHASE_EN defined an extra phase sequence runs at the end.
// ---------------------------------------------------------------------------
module tb_ce_gen_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sync_i;
   logic       cfg_wr_i;
   logic [1:0] cfg_ch_i;
   logic [7:0] cfg_div_i;
   logic       cfg_div2_i;
   logic [7:0] cfg_phase;
   logic [3:0] pending_o;
   logic [3:0] ce_o;

   int testCount = 0;
   int failCount = 0;
   int edgeNum   = 0;

   always #5 clk = ~clk;

   ce_gen_multi dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_i     (sync_i),
      .cfg_wr_i   (cfg_wr_i),
      .cfg_ch_i   (cfg_ch_i),
      .cfg_div_i  (cfg_div_i),
      .cfg_div2_i (cfg_div2_i),
`ifdef CE_GEN_PHASE_EN
      .cfg_phase_i(cfg_phase),
`endif
      .pending_o  (pending_o),
      .ce_o       (ce_o)
   );

   // Drive one cycle's worth of inputs; they are captured on the next edge.
   task automatic applyStimulus(input logic wr, input logic [1:0] ch,
                                input logic [7:0] div, input logic div2,
                                input logic [7:0] phase, input logic sync);
      cfg_wr_i   = wr;
      cfg_ch_i   = ch;
      cfg_div_i  = div;
      cfg_div2_i = div2;
      cfg_phase  = phase;
      sync_i     = sync;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 8'hFF, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b (edge %0d)",
                tag, observed, expected, edgeNum);
      end
   endtask

   task automatic runTo(input int target);
      while (edgeNum < target) begin
         @(posedge clk);
         #1;
         edgeNum++;
      end
   endtask

   // Holds reset for three edges, checks the reset state, then releases.
   task automatic releaseReset();
      rst_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ce", ce_o, 4'b0000);
      checkOutput("rst_pending", pending_o, 4'b0000);
      rst_n   = 1'b1;
      edgeNum = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      releaseReset();

      // Default divide 31: first pulse at edge 32, then every 32 cycles
      runTo(31);  checkOutput("pre_first", ce_o, 4'b0000);
      runTo(32);  checkOutput("first_pulse", ce_o, 4'b1111);
      runTo(33);  checkOutput("after_first", ce_o, 4'b0000);
      runTo(64);  checkOutput("second_pulse", ce_o, 4'b1111);

      // ch1 div=4 written mid-period: waits for the edge-96 terminal count
      runTo(74);  applyStimulus(1'b1, 2'd1, 8'd4, 1'b0, 8'hFF, 1'b0);
      runTo(75);  idle();
      checkOutput("ch1_pending", pending_o, 4'b0010);
      runTo(95);  checkOutput("ch1_still_pending", pending_o, 4'b0010);
      checkOutput("no_runt", ce_o, 4'b0000);
      runTo(96);  checkOutput("period_end", ce_o, 4'b1111);
      checkOutput("ch1_applied", pending_o, 4'b0000);
      runTo(100); checkOutput("ch1_gap", ce_o, 4'b0000);
      runTo(101); checkOutput("ch1_div4_a", ce_o, 4'b0010);
      runTo(106); checkOutput("ch1_div4_b", ce_o, 4'b0010);

      // ch2 div=2 div2=1 then sync at edge 108: pulses at 114, 120
      applyStimulus(1'b1, 2'd2, 8'd2, 1'b1, 8'hFF, 1'b0);
      runTo(107); applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 8'hFF, 1'b1);
      checkOutput("ch2_pending", pending_o, 4'b0100);
      runTo(108); idle();
      checkOutput("sync_clears_pending", pending_o, 4'b0000);
      checkOutput("sync_no_tc", ce_o, 4'b0000);
      runTo(111); checkOutput("div2_odd_tc_silent", ce_o, 4'b0000);
      runTo(113); checkOutput("ch1_after_sync", ce_o, 4'b0010);
      runTo(114); checkOutput("ch2_first", ce_o, 4'b0100);
      runTo(120); checkOutput("ch2_second", ce_o, 4'b0100);

      // ch3 div=0: applied at edge 140, then constantly high, even across sync
      applyStimulus(1'b1, 2'd3, 8'd0, 1'b0, 8'hFF, 1'b0);
      runTo(121); idle();
      checkOutput("ch3_pending", pending_o, 4'b1000);
      runTo(139); checkOutput("ch3_before", ce_o, 4'b0000);
      checkOutput("ch3_still_pending", pending_o, 4'b1000);
      runTo(140); checkOutput("ch3_apply", ce_o, 4'b1001);
      checkOutput("ch3_applied", pending_o, 4'b0000);
      runTo(141); checkOutput("ch3_const_a", ce_o, 4'b1000);
      runTo(143); checkOutput("ch3_const_b", ce_o, 4'b1010);
      runTo(144); checkOutput("ch3_const_c", ce_o, 4'b1100);
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 8'hFF, 1'b1);
      runTo(145); idle();
      checkOutput("ch3_sync", ce_o, 4'b1000);
      runTo(150); checkOutput("post_sync_ch1", ce_o, 4'b1010);

      // Write ch1 div=2 together with sync on ch1's terminal count (edge 155)
      runTo(154); checkOutput("pre_coincident", ce_o, 4'b1000);
      applyStimulus(1'b1, 2'd1, 8'd2, 1'b0, 8'hFF, 1'b1);
      runTo(155); idle();
      checkOutput("coincident_ce", ce_o, 4'b1010);
      checkOutput("coincident_pending", pending_o, 4'b0000);
      runTo(157); checkOutput("ch1_div2_gap", ce_o, 4'b1000);
      runTo(158); checkOutput("ch1_div2_a", ce_o, 4'b1010);
      runTo(161); checkOutput("ch1_div2_b", ce_o, 4'b1110);

      // Pending write discarded by a mid-operation asynchronous reset
      applyStimulus(1'b1, 2'd0, 8'd5, 1'b0, 8'hFF, 1'b0);
      runTo(162); idle();
      checkOutput("ch0_pending", pending_o, 4'b0001);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_ce", ce_o, 4'b0000);
      checkOutput("async_rst_pending", pending_o, 4'b0000);
      releaseReset();
      runTo(32);  checkOutput("rerelease_first", ce_o, 4'b1111);
      runTo(37);  checkOutput("rerelease_no_div5", ce_o, 4'b0000);
      runTo(64);  checkOutput("rerelease_second", ce_o, 4'b1111);

`ifdef CE_GEN_PHASE_EN
      // ch0/ch1 div=9 with phase 0 and 5; sync at edge 3
      releaseReset();
      applyStimulus(1'b1, 2'd0, 8'd9, 1'b0, 8'd0, 1'b0);
      runTo(1);   applyStimulus(1'b1, 2'd1, 8'd9, 1'b0, 8'd5, 1'b0);
      runTo(2);   applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 8'hFF, 1'b1);
      runTo(3);   idle();
      runTo(4);   checkOutput("phase0_first", ce_o, 4'b0001);
      runTo(8);   checkOutput("phase_gap", ce_o, 4'b0000);
      runTo(9);   checkOutput("phase5_first", ce_o, 4'b0010);
      runTo(14);  checkOutput("phase0_second", ce_o, 4'b0001);
      runTo(19);  checkOutput("phase5_second", ce_o, 4'b0010);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
